// File: rtl/polar_sc_scheduler.sv
// Successive-cancellation (SC) polar decoder schedule controller.
//
// This block walks the decoding tree one bit at a time. For each bit it:
//   1. issues LLR operations from that bit's start layer down to layer 1,
//   2. requests a hard decision on the bit,
//   3. requests a partial-sum update when the bit completes a subtree.
//
// The PE datapath, decision unit, partial-sum unit and frozen-bit table
// are all outside this module.
//
// Optional build macro: POLAR_SC_FROZEN_SKIP_EN
//   When defined, a frozen bit skips its layer-1 LLR operation and goes
//   straight to the decision step.
//
// Ports:
//   clk        : clock; all logic is on the rising edge
//   rst        : synchronous, active-high reset
//   start      : begin decoding one frame; ignored unless idle
//   busy       : high from the cycle after an accepted start through the done cycle
//   done       : one-cycle pulse when the frame is complete
//   op_valid   : LLR operation request to the PE datapath
//   op_ready   : the datapath accepts the operation this cycle
//   op_layer   : target layer of the operation (1..LOG2N)
//   op_is_g    : 1 = g-node operation, 0 = f-node operation
//   op_done    : pulse; the accepted operation has finished
//   bit_idx    : index of the bit currently being decoded
//   frozen_bit : frozen flag for bit_idx (combinational lookup)
//   dec_valid  : one-cycle pulse; make the hard decision on bit_idx
//   dec_frozen : frozen flag that accompanies dec_valid
//   ps_valid   : partial-sum update request, held until ps_done
//   ps_layers  : number of layers the partial sum propagates through
//   ps_done    : pulse; the partial-sum update has finished
module polar_sc_scheduler #(
  parameter int unsigned LOG2N           = 10,
  parameter int unsigned COUNTER_WIDTH   = 10,
  parameter int unsigned LAYER_OUT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic [LAYER_OUT_WIDTH-1:0] op_layer,
  output logic                       op_is_g,
  input  logic                       op_done,
  output logic [COUNTER_WIDTH-1:0]   bit_idx,
  input  logic                       frozen_bit,
  output logic                       dec_valid,
  output logic                       dec_frozen,
  output logic                       ps_valid,
  output logic [LAYER_OUT_WIDTH-1:0] ps_layers,
  input  logic                       ps_done
);

`ifdef POLAR_SC_FROZEN_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  // COUNTER_WIDTH equals LOG2N, so the last bit index (N-1) is all ones.
  localparam logic [COUNTER_WIDTH-1:0]   LastBit  = '1;
  localparam logic [LAYER_OUT_WIDTH-1:0] TopLayer = LAYER_OUT_WIDTH'(LOG2N);
  localparam logic [LAYER_OUT_WIDTH-1:0] Layer1   = LAYER_OUT_WIDTH'(1);
  localparam logic [LAYER_OUT_WIDTH-1:0] Layer2   = LAYER_OUT_WIDTH'(2);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDecide,
    StPsum,
    StFin
  } state_e;

  state_e                       state_q, state_d;
  logic [COUNTER_WIDTH-1:0]     bit_idx_q, bit_idx_d;
  logic [LAYER_OUT_WIDTH-1:0]   layer_q, layer_d;
  logic                         dec_frozen_q, dec_frozen_d;

  logic [LAYER_OUT_WIDTH-1:0]   psum_layers;
  logic [LAYER_OUT_WIDTH-1:0]   cur_start_layer;
  logic [COUNTER_WIDTH-1:0]     next_bit;
  logic                         skip_frozen;
  logic                         skip_issue;
  logic                         in_psum_req;

  function automatic logic [LAYER_OUT_WIDTH-1:0] trailing_zeros(
    input logic [COUNTER_WIDTH-1:0] v
  );
    logic [LAYER_OUT_WIDTH-1:0] n;
    logic                       stop;
    n    = '0;
    stop = 1'b0;
    for (int k = 0; k < COUNTER_WIDTH; k++) begin
      if (!stop) begin
        if (v[k]) stop = 1'b1;
        else      n    = n + Layer1;
      end
    end
    return n;
  endfunction

  function automatic logic [LAYER_OUT_WIDTH-1:0] trailing_ones(
    input logic [COUNTER_WIDTH-1:0] v
  );
    return trailing_zeros(~v);
  endfunction

  // Bit 0 starts at the root. Any other bit starts just above the lowest
  // subtree boundary it crosses.
  function automatic logic [LAYER_OUT_WIDTH-1:0] start_layer(
    input logic [COUNTER_WIDTH-1:0] v
  );
    if (v == '0) return TopLayer;
    return trailing_zeros(v) + Layer1;
  endfunction

  assign psum_layers     = trailing_ones(bit_idx_q);
  assign cur_start_layer = start_layer(bit_idx_q);
  assign next_bit        = bit_idx_q + COUNTER_WIDTH'(1);
  assign skip_frozen     = SkipEn && frozen_bit;
  // A frozen bit whose path starts at layer 1 needs no LLR operation at all.
  assign skip_issue      = skip_frozen && (layer_q == Layer1);
  assign in_psum_req     = (state_q == StPsum) && (bit_idx_q != LastBit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_idx_q    <= '0;
      layer_q      <= '0;
      dec_frozen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      layer_q      <= layer_d;
      dec_frozen_q <= dec_frozen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    layer_d   = layer_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          bit_idx_d = '0;
          layer_d   = TopLayer;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (skip_issue)    state_d = StDecide;
        else if (op_ready) state_d = StWait;
      end
      StWait: begin
        if (op_done) begin
          // A frozen bit in skip mode stops after its layer-2 operation.
          if ((layer_q == Layer1) || (skip_frozen && (layer_q == Layer2))) begin
            state_d = StDecide;
          end else begin
            layer_d = layer_q - Layer1;
            state_d = StIssue;
          end
        end
      end
      StDecide: begin
        state_d = StPsum;
      end
      StPsum: begin
        if (bit_idx_q == LastBit) begin
          state_d = StFin;
        end else if ((psum_layers == '0) || ps_done) begin
          bit_idx_d = next_bit;
          layer_d   = start_layer(next_bit);
          state_d   = StIssue;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture the frozen flag on entry to DECIDE; bit_idx is unchanged there.
    dec_frozen_d = (state_d == StDecide) ? frozen_bit : 1'b0;
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign op_valid   = (state_q == StIssue) && !skip_issue;
  assign op_layer   = op_valid ? layer_q : '0;
  assign op_is_g    = op_valid && (bit_idx_q != '0) && (layer_q == cur_start_layer);
  assign bit_idx    = bit_idx_q;
  assign dec_valid  = (state_q == StDecide);
  assign dec_frozen = dec_frozen_q;
  assign ps_layers  = in_psum_req ? psum_layers : '0;
  assign ps_valid   = in_psum_req && (psum_layers != '0);

endmodule

// File: tb/tb_polar_sc_scheduler.sv
// Directed self-checking bench for polar_sc_scheduler (LOG2N = 10).
// DUT outputs are sampled on the falling edge. A responder process drives
// op_done and ps_done 1 time unit after each falling edge.
module tb_polar_sc_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_layer;
  logic        op_is_g;
  logic        op_done;
  logic [9:0]  bit_idx;
  logic        frozen_bit;
  logic        dec_valid;
  logic        dec_frozen;
  logic        ps_valid;
  logic [3:0]  ps_layers;
  logic        ps_done;

  logic [1023:0] frozen_mask;
  logic          done_en;
  logic          inj_done;
  logic          pend_op;

  int n_checks;
  int n_fail;

  polar_sc_scheduler #(
    .LOG2N          (10),
    .COUNTER_WIDTH  (10),
    .LAYER_OUT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_layer  (op_layer),
    .op_is_g   (op_is_g),
    .op_done   (op_done),
    .bit_idx   (bit_idx),
    .frozen_bit(frozen_bit),
    .dec_valid (dec_valid),
    .dec_frozen(dec_frozen),
    .ps_valid  (ps_valid),
    .ps_layers (ps_layers),
    .ps_done   (ps_done)
  );

  assign frozen_bit = frozen_mask[bit_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath responder: op_done in the cycle after an accepted op, and
  // ps_done in the same cycle as ps_valid.
  initial begin
    op_done = 1'b0;
    ps_done = 1'b0;
    pend_op = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      op_done = (pend_op && done_en) || inj_done;
      pend_op = op_valid && op_ready && !rst;
      ps_done = ps_valid || inj_done;
    end
  end

  function automatic int tz(input int v);
    int n;
    n = 0;
    while (((v >> n) & 1) == 0 && n < 10) n++;
    return n;
  endfunction

  function automatic int t_ones(input int v);
    int n;
    n = 0;
    while (((v >> n) & 1) == 1 && n < 10) n++;
    return n;
  endfunction

  function automatic int sl(input int v);
    return (v == 0) ? 10 : tz(v) + 1;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    start       = 1'b0;
    op_ready    = 1'b1;
    done_en     = 1'b1;
    inj_done    = 1'b0;
    frozen_mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    do_reset();
    outs = {17'd0, busy, done, op_valid, op_layer, op_is_g, dec_valid, dec_frozen,
            ps_valid, ps_layers};
    n_checks++;
    if (outs !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    n_checks++;
    if (bit_idx !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx);
    end
  endtask

  task automatic test_full_frame();
    int exp_bit, exp_layer, decs, last_dec_cyc, ps7_seen;
    bit first, finished;
    do_reset();
    pulse_start();
    exp_bit = 0; exp_layer = 10; first = 1'b1; decs = 0;
    last_dec_cyc = -10; ps7_seen = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (int'(bit_idx) != exp_bit) begin
        n_checks++;
        if (int'(bit_idx) != exp_bit + 1 || exp_layer != 0) begin
          n_fail++;
          $display("FAIL bit_advance: got bit %0d expected %0d (layers left %0d)",
                   bit_idx, exp_bit + 1, exp_layer);
        end
        exp_bit++;
        exp_layer = sl(exp_bit);
        first = 1'b1;
      end
      if (op_valid) begin
        n_checks++;
        if (int'(op_layer) != exp_layer || op_is_g !== (first && exp_bit != 0)) begin
          n_fail++;
          $display("FAIL op_seq bit %0d: got layer %0d g %0b expected layer %0d g %0b",
                   exp_bit, op_layer, op_is_g, exp_layer, first && exp_bit != 0);
        end
        first = 1'b0;
        exp_layer--;
      end
      if (dec_valid) begin
        decs++;
        n_checks++;
        if (exp_layer != 0 || dec_frozen !== 1'b0) begin
          n_fail++;
          $display("FAIL decide bit %0d: got layers left %0d frozen %0b expected 0 0",
                   exp_bit, exp_layer, dec_frozen);
        end
        if (exp_bit == 1023) last_dec_cyc = cyc;
      end
      if (ps_valid) begin
        if (exp_bit == 7) ps7_seen++;
        n_checks++;
        if (int'(ps_layers) != t_ones(exp_bit) || exp_bit == 1023) begin
          n_fail++;
          $display("FAIL ps_layers bit %0d: got %0d expected %0d",
                   exp_bit, ps_layers, t_ones(exp_bit));
        end
      end
      if (cyc == last_dec_cyc + 1) begin
        n_checks++;
        if (ps_valid !== 1'b0 || ps_layers !== 4'd0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL last_psum: got ps_valid %0b ps_layers %0d done %0b expected 0 0 0",
                   ps_valid, ps_layers, done);
        end
      end
      if (done) begin
        finished = 1'b1;
        n_checks++;
        if (cyc != last_dec_cyc + 2 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL done_timing: got cycles after last decide %0d busy %0b expected 2 1",
                   cyc - last_dec_cyc, busy);
        end
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL frame_timeout: got no done expected done");
    end
    n_checks++;
    if (decs != 1024) begin
      n_fail++;
      $display("FAIL dec_count: got %0d expected 1024", decs);
    end
    n_checks++;
    if (ps7_seen != 1) begin
      n_fail++;
      $display("FAIL ps7_seen: got %0d expected 1", ps7_seen);
    end
    // start during the done cycle is not accepted
    pulse_start();
    n_checks++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_fin: got busy %0b op_valid %0b expected 0 0", busy, op_valid);
    end
  endtask

  task automatic test_ready_stall();
    do_reset();
    op_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (op_valid !== 1'b1 || op_layer !== 4'd10 || op_is_g !== 1'b0 || bit_idx !== 10'd0) begin
        n_fail++;
        $display("FAIL stall_hold %0d: got v %0b layer %0d g %0b bit %0d expected 1 10 0 0",
                 i, op_valid, op_layer, op_is_g, bit_idx);
      end
      @(negedge clk);
    end
    op_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (op_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_wait: got op_valid %0b busy %0b expected 0 1", op_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (op_valid !== 1'b1 || op_layer !== 4'd9) begin
      n_fail++;
      $display("FAIL stall_next_op: got v %0b layer %0d expected 1 9", op_valid, op_layer);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    do_reset();
    pulse_start();
    hit = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bit_idx == 10'd3 && op_valid) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    done_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!hit || op_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait: got hit %0b op_valid %0b busy %0b expected 1 0 1",
               hit, op_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || op_valid !== 1'b0 || bit_idx !== 10'd0 || ps_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy %0b op_valid %0b bit %0d ps %0b expected 0 0 0 0",
               busy, op_valid, bit_idx, ps_valid);
    end
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || op_valid !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_done: got busy %0b op_valid %0b dec %0b expected 0 0 0",
               busy, op_valid, dec_valid);
    end
    done_en = 1'b1;
    pulse_start();
    n_checks++;
    if (op_valid !== 1'b1 || op_layer !== 4'd10 || bit_idx !== 10'd0 || op_is_g !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got v %0b layer %0d bit %0d g %0b expected 1 10 0 0",
               op_valid, op_layer, bit_idx, op_is_g);
    end
  endtask

  task automatic test_start_while_busy();
    do_reset();
    pulse_start();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bit_idx == 10'd2) break;
      @(negedge clk);
    end
    pulse_start();
    n_checks++;
    if (bit_idx < 10'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start: got bit %0d busy %0b expected >=2 1", bit_idx, busy);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (bit_idx < 10'd2) begin
      n_fail++;
      $display("FAIL busy_start_later: got bit %0d expected >=2", bit_idx);
    end
  endtask

  task automatic test_frozen();
    int psum_cyc, dec1_cyc, ops1, ops2, exp_gap, exp_ops1, exp_ops2;
    do_reset();
    frozen_mask[1] = 1'b1;
    frozen_mask[2] = 1'b1;
`ifdef POLAR_SC_FROZEN_SKIP_EN
    exp_gap = 2; exp_ops1 = 0; exp_ops2 = 1;
`else
    exp_gap = 3; exp_ops1 = 1; exp_ops2 = 2;
`endif
    psum_cyc = -100; dec1_cyc = 0; ops1 = 0; ops2 = 0;
    pulse_start();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bit_idx == 10'd3) break;
      if (dec_valid && bit_idx == 10'd0) begin
        psum_cyc = cyc + 1;
        n_checks++;
        if (dec_frozen !== 1'b0) begin
          n_fail++;
          $display("FAIL frozen_b0: got %0b expected 0", dec_frozen);
        end
      end
      if (op_valid && bit_idx == 10'd1) begin
        ops1++;
        n_checks++;
        if (op_layer !== 4'd1 || op_is_g !== 1'b1) begin
          n_fail++;
          $display("FAIL frozen_b1_op: got layer %0d g %0b expected 1 1", op_layer, op_is_g);
        end
      end
      if (op_valid && bit_idx == 10'd2) ops2++;
      if (dec_valid && bit_idx != 10'd0) begin
        if (bit_idx == 10'd1) dec1_cyc = cyc;
        n_checks++;
        if (dec_frozen !== 1'b1) begin
          n_fail++;
          $display("FAIL frozen_flag bit %0d: got %0b expected 1", bit_idx, dec_frozen);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (ops1 != exp_ops1 || ops2 != exp_ops2) begin
      n_fail++;
      $display("FAIL frozen_ops: got %0d %0d expected %0d %0d", ops1, ops2, exp_ops1, exp_ops2);
    end
    n_checks++;
    if (dec1_cyc - psum_cyc != exp_gap) begin
      n_fail++;
      $display("FAIL frozen_gap: got %0d expected %0d", dec1_cyc - psum_cyc, exp_gap);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_frame();
    test_ready_stall();
    test_reset_mid_frame();
    test_start_while_busy();
    test_frozen();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/polar_sc_scheduler.md
POLAR_SC_SCHEDULER -- requirements
Module: polar_sc_scheduler

Interface
REQ-001 Parameter LOG2N, default 10, log2 of code length N (N = 2^LOG2N bits per frame).
REQ-002 Parameter COUNTER_WIDTH, default 10, width of bit index; SHALL equal LOG2N.
REQ-003 Parameter LAYER_OUT_WIDTH, default 4, width of layer fields; SHALL hold value LOG2N.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin decoding one frame; ignored unless idle.
REQ-007 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-008 done  out  1  one-cycle pulse, frame complete.
REQ-009 op_valid  out  1  LLR operation request to PE datapath.
REQ-010 op_ready  in  1  datapath accepts op this cycle.
REQ-011 op_layer  out  LAYER_OUT_WIDTH  target layer of op (1..LOG2N).
REQ-012 op_is_g  out  1  1 = g-node op, 0 = f-node op.
REQ-013 op_done  in  1  pulse, accepted op finished.
REQ-014 bit_idx  out  COUNTER_WIDTH  current decoded bit index.
REQ-015 frozen_bit  in  1  frozen flag for bit_idx, combinational lookup, valid same cycle.
REQ-016 dec_valid  out  1  one-cycle pulse, make hard decision on bit_idx.
REQ-017 dec_frozen  out  1  frozen_bit registered with dec_valid.
REQ-018 ps_valid  out  1  partial-sum update request, held until ps_done.
REQ-019 ps_layers  out  LAYER_OUT_WIDTH  number of layers to propagate.
REQ-020 ps_done  in  1  pulse, partial-sum update finished.

Function
REQ-021 States: IDLE, ISSUE, WAIT, DECIDE, PSUM, FIN; encoding free.
REQ-022 start_layer(i) SHALL be LOG2N for i=0, else (trailing-zero count of i)+1.
REQ-023 IDLE + start: bit_idx<=0, layer<=LOG2N, next ISSUE; busy high next cycle.
REQ-024 ISSUE: op_valid=1, op_layer=layer, op_is_g = (bit_idx!=0 && layer==start_layer(bit_idx)); op_valid/op_layer/op_is_g stable until op_ready.
REQ-025 ISSUE and op_ready: next WAIT; op_valid low in WAIT.
REQ-026 WAIT and op_done: layer==1 -> DECIDE; else layer<=layer-1, next ISSUE.
REQ-027 op_done outside WAIT SHALL be ignored.
REQ-028 DECIDE: dec_valid=1 for exactly one cycle, dec_frozen=frozen_bit; next PSUM.
REQ-029 PSUM with bit_idx==N-1: no ps request, next FIN.
REQ-030 PSUM otherwise: ps_layers = trailing-one count of bit_idx; if 0, no ps_valid; else ps_valid held until ps_done.
REQ-031 PSUM exit (ps_layers==0, or ps_done): bit_idx<=bit_idx+1, layer<=start_layer(bit_idx+1), next ISSUE.
REQ-032 FIN: done=1 one cycle, busy=1 in that cycle, next IDLE.
REQ-033 start in any non-IDLE state SHALL be ignored; start and FIN same cycle not accepted.
REQ-034 bit_idx SHALL never wrap; frame ends at N-1.
REQ-035 Minimum per op: 2 cycles (ISSUE+WAIT) with op_ready and op_done immediate.

Reset
REQ-036 rst SHALL force IDLE next edge from any state, abandoning any op in flight.
REQ-037 Reset values: busy=0, done=0, op_valid=0, op_layer=0, op_is_g=0, bit_idx=0, dec_valid=0, dec_frozen=0, ps_valid=0, ps_layers=0.
REQ-038 op_done/ps_done arriving after reset SHALL be ignored.

Configuration
REQ-039 Macro POLAR_SC_FROZEN_SKIP_EN defined: when frozen_bit=1, ops at layer 1 for that bit SHALL not be issued; from layer 2 op_done go to DECIDE; if start_layer==1, go ISSUE->DECIDE directly without op_valid.
REQ-040 Macro undefined: all layers start_layer..1 issued for every bit regardless of frozen_bit.

Verification
REQ-041 LOG2N=10, op_ready/op_done immediate, ps_done immediate: start -> bit 0 issues layers 10..1 all f; done after all 1024 bits, exactly 1024 dec_valid pulses.
REQ-042 bit_idx=8 -> first op layer 4 op_is_g=1, then layers 3,2,1 f; bit_idx=7 PSUM -> ps_layers=3.
REQ-043 op_ready held low 5 cycles in ISSUE -> op_valid/op_layer stable 5 cycles, no state advance.
REQ-044 rst asserted in WAIT mid-frame -> next cycle IDLE, busy=0, later op_done ignored, new start decodes from bit 0.
REQ-045 POLAR_SC_FROZEN_SKIP_EN defined, bit 1 frozen -> no op_valid for bit 1, dec_valid two cycles after bit 0 PSUM exit; undefined -> one g op at layer 1 issued.
REQ-046 start pulsed while busy -> ignored; bit_idx=1023 PSUM -> no ps_valid, done pulse next cycle.
